// File: rtl/baud_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen_if
// Description : Control and status bundle of the baud-rate tick generator.
//               The master side programs the divisor, starts runs and
//               consumes the ticks; the slave side is the generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface baud_tick_gen_if #(
  parameter int INT_BITS  = 11,
  parameter int FRAC_BITS = 4,
  parameter int OSR_BITS  = 4
);
  logic                 enable;
  logic                 mode;
  logic                 start;
  logic [INT_BITS-1:0]  div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 div_load;
  logic                 sample_tick;
  logic                 bit_tick;
  logic                 busy;
  logic [INT_BITS-1:0]  count;
  logic [OSR_BITS-1:0]  os_count;

  modport master (
    output enable, mode, start, div_int, div_frac, div_load,
    input  sample_tick, bit_tick, busy, count, os_count
  );

  modport slave (
    input  enable, mode, start, div_int, div_frac, div_load,
    output sample_tick, bit_tick, busy, count, os_count
  );
endinterface
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Baud-rate tick generator. Divides clk by (div_int + 1), with
//               an optional fractional accumulator that stretches individual
//               sample periods by one cycle, and emits a one-cycle
//               sample_tick plus a bit_tick on every 2^OSR_BITS-th sample.
//               Free-running (mode 0) or one-shot (mode 1, one bit per start).
//               Build option: define TICK_GEN_FRAC_EN to implement the
//               fractional divisor; otherwise div_frac is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int INT_BITS  = 11,
  parameter int FRAC_BITS = 4,
  parameter int OSR_BITS  = 4,
  parameter int RESET_DIV = 650
) (
  input wire             clk,
  input wire             reset_n,
  baud_tick_gen_if.slave bus
);

  localparam logic [INT_BITS-1:0] c_RESET_DIV = INT_BITS'(RESET_DIV);
  localparam logic [OSR_BITS-1:0] c_OS_LAST   = {OSR_BITS{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [INT_BITS-1:0] r_count;
  logic [OSR_BITS-1:0] r_os_count;
  logic [INT_BITS-1:0] r_act_int;
  logic [INT_BITS-1:0] r_pend_int;
  logic                r_pend_valid;
  logic                r_running;

  // --------------------------------------------------------------------------
  // Decode of registered state
  // --------------------------------------------------------------------------
  logic                w_stretch;
  logic                w_run_en;
  logic [INT_BITS:0]   w_final;
  logic                w_sample_tick;
  logic                w_bit_tick;
  logic                w_take_div;

  assign w_run_en = r_running & bus.enable;

  // One bit wider than the counter so div_int at all-ones plus a stretch
  // does not alias to a terminal count of zero; that corner combination is
  // not usable (the counter cannot reach it), so keep div_frac at 0 there.
  assign w_final       = {1'b0, r_act_int} + {{INT_BITS{1'b0}}, w_stretch};
  assign w_sample_tick = w_run_en & ({1'b0, r_count} == w_final);
  assign w_bit_tick    = w_sample_tick & (r_os_count == c_OS_LAST);

  // A new divisor may only become active on a period boundary, or at any
  // time while the generator is idle.
  assign w_take_div = w_sample_tick | ~r_running;

  // --------------------------------------------------------------------------
  // Run control: free-running mode is always running; one-shot mode runs
  // from start until the bit_tick that closes the bit.
  // --------------------------------------------------------------------------
  // Track whether the generator is currently producing ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_running <= 1'b0;
    end else if (!bus.mode) begin
      r_running <= 1'b1;
    end else if (bus.start) begin
      r_running <= 1'b1;
    end else if (w_bit_tick) begin
      r_running <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Prescale and oversampling counters. start wins over a coincident tick so
  // a restart always begins a fresh, full-length bit.
  // --------------------------------------------------------------------------
  // Advance the prescaler each enabled cycle and the sample index per tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_os_count <= '0;
    end else if (bus.start) begin
      r_count    <= '0;
      r_os_count <= '0;
    end else if (w_sample_tick) begin
      r_count    <= '0;
      r_os_count <= r_os_count + 1'b1;
    end else if (w_run_en) begin
      r_count    <= r_count + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Integer divisor: shadow register plus active copy. A load coinciding with
  // the commit point bypasses the shadow so the newest value always wins.
  // --------------------------------------------------------------------------
  // Capture loads into the shadow and commit them on a period boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_int    <= c_RESET_DIV;
      r_pend_int   <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (bus.div_load) begin
        r_pend_int <= bus.div_int;
      end
      if (w_take_div) begin
        if (bus.div_load) begin
          r_act_int <= bus.div_int;
        end else if (r_pend_valid) begin
          r_act_int <= r_pend_int;
        end
        r_pend_valid <= 1'b0;
      end else if (bus.div_load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

`ifdef TICK_GEN_FRAC_EN
  // --------------------------------------------------------------------------
  // Fractional divisor and accumulator. Each sample period adds div_frac to
  // the accumulator; the carry out lengthens the following period by one.
  // --------------------------------------------------------------------------
  logic [FRAC_BITS-1:0] r_act_frac;
  logic [FRAC_BITS-1:0] r_pend_frac;
  logic [FRAC_BITS-1:0] r_acc;
  logic                 r_stretch;

  // Fractional divisor follows the same shadow/commit rule as the integer part
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_frac  <= '0;
      r_pend_frac <= '0;
    end else begin
      if (bus.div_load) begin
        r_pend_frac <= bus.div_frac;
      end
      if (w_take_div) begin
        if (bus.div_load) begin
          r_act_frac <= bus.div_frac;
        end else if (r_pend_valid) begin
          r_act_frac <= r_pend_frac;
        end
      end
    end
  end

  // Accumulate the fraction once per sample period; carry becomes the stretch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (bus.start) begin
      r_acc     <= '0;
      r_stretch <= 1'b0;
    end else if (w_sample_tick) begin
      {r_stretch, r_acc} <= {1'b0, r_acc} + {1'b0, r_act_frac};
    end
  end

  assign w_stretch = r_stretch;
`else
  // Integer-only build: every period is exactly div_int + 1 cycles and the
  // fractional input is deliberately left unconnected.
  logic w_unused_frac;
  assign w_unused_frac = ^bus.div_frac;
  assign w_stretch     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs. In one-shot mode busy stays high through enable gaps because a
  // run is still in progress; in free-running mode it follows enable.
  // --------------------------------------------------------------------------
  assign bus.sample_tick = w_sample_tick;
  assign bus.bit_tick    = w_bit_tick;
  assign bus.busy        = r_running & (bus.mode | bus.enable);
  assign bus.count       = r_count;
  assign bus.os_count    = r_os_count;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_tick_gen
// Description : Directed self-checking bench for baud_tick_gen. Expected tick
//               spacings are queued as each step is driven and popped as the
//               generator produces the corresponding tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;

  localparam int INT_BITS     = 11;
  localparam int FRAC_BITS    = 4;
  localparam int OSR_BITS     = 4;
  localparam int RESET_DIV    = 650;
  localparam int RESET_PERIOD = RESET_DIV + 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  baud_tick_gen_if #(
    .INT_BITS (INT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .OSR_BITS (OSR_BITS)
  ) bus ();

  baud_tick_gen #(
    .INT_BITS (INT_BITS),
    .FRAC_BITS(FRAC_BITS),
    .OSR_BITS (OSR_BITS),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  // Advance one clock and settle past the edge before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %0d, expected value missing from queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Cycles until the next sample_tick, bounded by budget
  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.sample_tick !== 1'b1 && cyc < budget);
  endtask

  // Cycles until the next bit_tick, bounded by budget
  task automatic wait_bit(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.bit_tick !== 1'b1 && cyc < budget);
  endtask

  task automatic load_div(input int di, input int df);
    bus.div_int  = INT_BITS'(di);
    bus.div_frac = FRAC_BITS'(df);
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int w;
    int total;
    int ticks;
    int busy_seen;
    int st;
    int acc;

    bus.enable   = 1'b1;
    bus.mode     = 1'b0;
    bus.start    = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_load = 1'b0;

    // ---------------- reset defaults ----------------
    repeat (3) @(negedge clk);
    check("rst_count",    bus.count,       0);
    check("rst_os_count", bus.os_count,    0);
    check("rst_busy",     bus.busy,        0);
    check("rst_sample",   bus.sample_tick, 0);
    check("rst_bit",      bus.bit_tick,    0);
    @(negedge clk);
    reset_n = 1'b1;

    push_exp(RESET_PERIOD);
    wait_tick(RESET_PERIOD + 20, g);
    sb_check("rst_first_tick", g);
    check("rst_busy_run", bus.busy, 1);
    check("rst_bit_1", bus.bit_tick, 0);
    for (int k = 2; k <= 16; k++) begin
      push_exp(RESET_PERIOD);
      wait_tick(RESET_PERIOD + 20, g);
      sb_check($sformatf("rst_gap_%0d", k), g);
      check($sformatf("rst_bit_%0d", k), bus.bit_tick, (k == 16));
    end
    push_exp(16 * RESET_PERIOD);
    wait_bit(16 * RESET_PERIOD + 50, g);
    sb_check("rst_bit_period", g);

    // ---------------- minimum divisor ----------------
    load_div(0, 0);
    check("min_tick_after_load", bus.sample_tick, 1);
    for (int k = 0; k < 4; k++) begin
      push_exp(1);
      wait_tick(5, g);
      sb_check($sformatf("min_gap_%0d", k), g);
    end
    pulse_start();
    push_exp(16);
    wait_bit(40, g);
    sb_check("min_first_bit", g + 1);
    push_exp(16);
    wait_bit(40, g);
    sb_check("min_bit_period", g);

    // ---------------- fractional divisor ----------------
    load_div(3, 8);
    st    = 0;
    acc   = 0;
    total = 0;
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      push_exp(4 + st);
      wait_tick(20, g);
      if (k == 1) g = g + 1;
      sb_check($sformatf("frac_gap_%0d", k), g);
      total += g;
      check($sformatf("frac_bit_%0d", k), bus.bit_tick, (k == 16));
`ifdef TICK_GEN_FRAC_EN
      acc = acc + 8;
      st  = (acc >= 16) ? 1 : 0;
      acc = acc % 16;
`endif
    end
`ifdef TICK_GEN_FRAC_EN
    check("frac_bit_latency", total, 71);
`else
    check("frac_bit_latency", total, 64);
`endif

    // ---------------- divisor update mid-period ----------------
    load_div(4, 0);
    pulse_start();
    total = 1;
    g = 0;
    while (bus.count !== INT_BITS'(2) && g < 10) begin
      step();
      g++;
    end
    total += g;
    check("upd_count_at_load", bus.count, 2);
    load_div(9, 0);
    total += 1;
    push_exp(5);
    wait_tick(20, w);
    total += w;
    sb_check("upd_current_period", total);
    check("upd_end_count", bus.count, 4);
    for (int k = 0; k < 2; k++) begin
      push_exp(10);
      wait_tick(30, g);
      sb_check($sformatf("upd_new_period_%0d", k), g);
    end

    // ---------------- enable gap ----------------
    total = 0;
    repeat (3) begin
      step();
      total++;
    end
    bus.enable = 1'b0;
    ticks     = 0;
    busy_seen = 0;
    repeat (7) begin
      step();
      total++;
      if (bus.sample_tick === 1'b1) ticks++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check("gap_no_ticks", ticks, 0);
    check("gap_busy_low", busy_seen, 0);
    check("gap_count_frozen", bus.count, 2);
    bus.enable = 1'b1;
    push_exp(17);
    wait_tick(40, w);
    total += w;
    sb_check("gap_period", total);

    // ---------------- asynchronous reset mid-period ----------------
    repeat (4) step();
    load_div(5, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count",    bus.count,    0);
    check("arst_os_count", bus.os_count, 0);
    check("arst_busy",     bus.busy,     0);
    check("arst_sample",   bus.sample_tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push_exp(RESET_PERIOD);
    wait_tick(RESET_PERIOD + 20, g);
    sb_check("arst_first_tick", g);
    push_exp(RESET_PERIOD);
    wait_tick(RESET_PERIOD + 20, g);
    sb_check("arst_pending_dropped", g);

    // ---------------- one-shot ----------------
    @(negedge clk);
    reset_n  = 1'b0;
    bus.mode = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    ticks     = 0;
    busy_seen = 0;
    repeat (20) begin
      step();
      if (bus.sample_tick === 1'b1) ticks++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check("os_idle_ticks", ticks, 0);
    check("os_idle_busy",  busy_seen, 0);
    load_div(1, 0);
    pulse_start();
    check("os_busy_after_start", bus.busy, 1);
    for (int k = 1; k <= 16; k++) begin
      push_exp(2);
      wait_tick(10, g);
      if (k == 1) g = g + 1;
      sb_check($sformatf("os_gap_%0d", k), g);
      check($sformatf("os_bit_%0d", k), bus.bit_tick, (k == 16));
    end
    step();
    check("os_busy_done",  bus.busy,     0);
    check("os_count_done", bus.count,    0);
    check("os_os_done",    bus.os_count, 0);
    ticks     = 0;
    busy_seen = 0;
    repeat (30) begin
      step();
      if (bus.sample_tick === 1'b1) ticks++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check("os_no_more_ticks", ticks, 0);
    check("os_stays_idle",    busy_seen, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART transmitter and receiver. It divides `clk` by a runtime-programmable divisor with an optional fractional part, and emits a one-cycle oversampling tick plus a bit tick every 2^OSR_BITS sample ticks. It supports free-running and one-shot modes, and takes divisor updates glitch-free on a period boundary.

## Interface
- `INT_BITS`, 11: width of the integer divisor and the prescale counter.
- `FRAC_BITS`, 4: width of the fractional divisor and the accumulator. A fraction step is 1/2^FRAC_BITS.
- `OSR_BITS`, 4: oversampling ratio is 2^OSR_BITS (16).
- `RESET_DIV`, 650: integer divisor loaded at reset (100 MHz / (9600·16) − 1). The reset fractional divisor is 0.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  count enable; low freezes all counters.
- `mode`  in  1  0 = free-running, 1 = one-shot.
- `start`  in  1  synchronous pulse; clears counters; in one-shot mode also arms a run.
- `div_int`  in  INT_BITS  period = div_int + 1 cycles.
- `div_frac`  in  FRAC_BITS  fractional addend per sample period.
- `div_load`  in  1  captures `div_int`/`div_frac` into the pending shadow.
- `sample_tick`  out  1  one-cycle oversampling tick.
- `bit_tick`  out  1  one-cycle tick, coincident with the last sample_tick of a bit.
- `busy`  out  1  generator running.
- `count`  out  INT_BITS  prescale counter value.
- `os_count`  out  OSR_BITS  sample index within the bit.

## Operation
- State: `count`, `os_count`, `acc` (FRAC_BITS), `stretch` (1 bit), active divisor, pending divisor plus `pend_valid`, `running`.
- `running`:
  - mode 0: `running` = 1 permanently.
  - mode 1: set by `start`; cleared on the edge after `bit_tick`.
- `busy` = `running` & (mode | `enable`).
- `final` = active div_int + `stretch`.
- `sample_tick` = `running` & `enable` & (`count` == `final`). It is a combinational decode of registered state.
- On `sample_tick`:
  - `count` ← 0.
  - {`stretch`, `acc`} ← `acc` + active div_frac. A carry lengthens the next period by one cycle.
  - `os_count` ← `os_count` + 1, wrapping at 2^OSR_BITS.
- Otherwise, when `running` & `enable`: `count` ← `count` + 1.
- `bit_tick` = `sample_tick` & (`os_count` == 2^OSR_BITS − 1).
- Divisor update:
  - `div_load` writes the shadow and sets `pend_valid`.
  - The active divisor takes the shadow on a `sample_tick` or while `running` = 0, then `pend_valid` clears.
  - If `div_load` and `sample_tick` occur in the same cycle, the incoming value is applied directly.
- `start`: `count`, `os_count`, `acc`, `stretch` ← 0. `start` has priority over `sample_tick` in the same cycle. `start` while running in one-shot mode restarts the bit.
- `div_int` = 0 gives `sample_tick` on every enabled cycle. Fractional stretch still applies.

## Timing
- Reset values:
  - All outputs 0; `acc`, `stretch`, `pend_valid` 0; `running` 0.
  - Active divisor = `RESET_DIV`/0.
  - After reset with mode 0, `running` is 1 from the first edge.
- First `sample_tick` occurs div_int + 1 enabled cycles after reset/start. No extra latency.
- Steady-state period is div_int + 1 + `stretch` enabled cycles. Cycles with `enable` low add no count and assert no tick.
- One-shot run: exactly 2^OSR_BITS `sample_tick`s, the last with `bit_tick`. `busy` falls on the edge after `bit_tick`. `count`/`os_count` then read 0.
- `reset_n` low mid-period clears everything immediately, including a pending divisor.

## Configuration
- `TICK_GEN_FRAC_EN` defined: fractional accumulator and stretch are implemented as above.
- `TICK_GEN_FRAC_EN` undefined:
  - `div_frac` is ignored; `acc` and `stretch` are not built.
  - `final` = div_int; every period is exactly div_int + 1 cycles.
  - The `div_frac` port remains present and unused.

## Test plan
- **Reset defaults:** reset, mode 0, `enable` = 1 → `sample_tick` every 651 cycles; `bit_tick` every 10416 cycles, coincident with the 16th `sample_tick`.
- **Fractional divisor:** `div_int` = 3, `div_frac` = 8 (0.5) → periods 4,4,5,4,5,…; first `bit_tick` 71 cycles after `start`. With the macro undefined → 64 cycles.
- **Divisor update mid-period:** `div_int` = 4 active; `div_load` with 9 at `count` = 2 → current period still ends at `count` 4; next period is 10 cycles.
- **One-shot:** mode 1, `div_int` = 1, `start` pulse → `busy` = 1; 16 `sample_tick`s 2 cycles apart; single `bit_tick` on the 16th; `busy` 0 the following cycle; no further ticks.
- **Enable gap and reset:** `enable` low for 7 cycles mid-period → that period is 7 cycles longer with no ticks. Then `reset_n` pulse mid-period → outputs 0 asynchronously; next period uses `RESET_DIV`.
- **Minimum divisor:** `div_int` = 0, `div_frac` = 0 → `sample_tick` every cycle; `bit_tick` every 16 cycles.
